// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder evaluation per clock, LSB first.
// Optional signed-overflow output V is enabled by defining SERIAL_ADD_OVF_EN.

// Team 1-bit full-adder cell, evaluated once per clock by the serial datapath.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             Co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic             carry_q, carry_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             v_q, v_d;
`endif

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_vec;

    full_adder_cell u_fa (
        .a_i  (areg_q[0]),
        .b_i  (breg_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_sum),
        .co_o (fa_carry)
    );

    // acc_q keeps the WIDTH-1 most recent sum bits; with the live bit on top
    // this is the complete sum on the last-bit cycle.
    assign sum_vec = {fa_sum, acc_q};

    // NOTE: every _d is given its hold value first, so no branch can leave it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        breg_d  = breg_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
`ifdef SERIAL_ADD_OVF_EN
        v_d     = v_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    areg_d  = A;
                    breg_d  = B;
                    carry_d = Ci;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                carry_d = fa_carry;
                acc_d   = sum_vec[WIDTH-1:1];
                areg_d  = areg_q >> 1;
                breg_d  = breg_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    s_d     = sum_vec;
                    co_d    = fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this cycle
                    v_d     = carry_q ^ fa_carry;
`endif
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset as well as the FSM, because an
    // aborted operation must leave S/Co reading 0 and no partial result behind.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
`ifdef SERIAL_ADD_OVF_EN
            v_q     <= v_d;
`endif
        end
    end

    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_DONE);
    assign S    = s_q;
    assign Co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign V    = v_q;
`endif

endmodule
